mem_arb_lat: RTL and testbench

Parametrised single-port word memory, shared by an instruction-fetch port and a data port through a round-robin arbiter. Read latency is programmable; byte-masked writes complete in one cycle. Each port has a req/valid handshake, so the core pipeline stalls on its own `valid` instead of on a global ready. It replaces the fixed-size, fixed-latency text/data memory and sits between the fetch and memory stages and the on-chip RAM.

---
 rtl/mem_arb_lat.sv | 162 ++++++++++++++++
 tb/tb_mem_arb_lat.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_lat.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_lat
// Brief    : Single-port word RAM shared by a fetch port and a data port via a
//            round-robin arbiter, with programmable read latency and one-cycle
//            byte-masked writes. Optional macro MEM_OOR_ERR_EN enables fast
//            error completion for out-of-range addresses.
// Revision : 1.0
// ============================================================================
module mem_arb_lat #(
    parameter int    WORDS     = 1024,
    parameter int    ADDR_BITS = 10,
    parameter int    LATENCY   = 6,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_valid,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_be,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_valid,
    output logic                 d_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0]           c_last  = 5'(LATENCY - 1);
    localparam logic [ADDR_BITS:0]   c_words = (ADDR_BITS + 1)'(WORDS);
`ifdef MEM_OOR_ERR_EN
    localparam logic                 c_oor_err = 1'b1;
`else
    localparam logic                 c_oor_err = 1'b0;
`endif

    logic [31:0]          mem [WORDS];

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic                 r_last_i;
    logic                 r_port_d;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_oor;

    logic                 w_i_oor;
    logic                 w_d_oor;
    logic                 w_accept;
    logic                 w_grant_d;
    logic                 w_acc_oor;
    logic                 w_acc_wr;
    logic [ADDR_BITS-1:0] w_acc_addr;
    logic [31:0]          w_rd_word;

    // Array preload only; the array itself has no reset so contents survive it.
    initial begin
        for (int k = 0; k < WORDS; k++) mem[k] = 32'h0;
    end

    assign w_i_oor    = {1'b0, i_addr} >= c_words;
    assign w_d_oor    = {1'b0, d_addr} >= c_words;
    assign w_accept   = (r_state == S_IDLE) && (i_req || d_req);
    assign w_grant_d  = d_req && (!i_req || r_last_i);
    assign w_acc_addr = w_grant_d ? d_addr : i_addr;
    assign w_acc_oor  = w_grant_d ? w_d_oor : w_i_oor;
    assign w_acc_wr   = w_grant_d && d_we;
    assign w_rd_word  = r_oor ? 32'h0 : mem[r_addr];

    always_ff @(posedge clk) begin
        if (reset && w_accept && w_acc_wr && !w_acc_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) mem[d_addr][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_last_i <= 1'b1;
            r_port_d <= 1'b0;
            r_addr   <= '0;
            r_oor    <= 1'b0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
            i_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
            busy     <= 1'b0;
`ifdef MEM_OOR_ERR_EN
            i_err    <= 1'b0;
            d_err    <= 1'b0;
`endif
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
`ifdef MEM_OOR_ERR_EN
            i_err   <= 1'b0;
            d_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_port_d <= w_grant_d;
                        r_last_i <= !w_grant_d;
                        r_addr   <= w_acc_addr;
                        r_oor    <= w_acc_oor;
                        r_cnt    <= 5'd0;
                        busy     <= 1'b1;
                        // Writes and flagged out-of-range accesses skip the read countdown.
                        if (w_acc_wr || (w_acc_oor && c_oor_err)) r_state <= S_DONE;
                        else                                       r_state <= S_RD;
                        if (w_acc_oor && c_oor_err) begin
                            if (w_grant_d) d_rdata <= 32'h0;
                            else           i_rdata <= 32'h0;
                        end
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_last) begin
                        r_state <= S_DONE;
                        if (r_port_d) d_rdata <= w_rd_word;
                        else          i_rdata <= w_rd_word;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (r_port_d) d_valid <= 1'b1;
                    else          i_valid <= 1'b1;
`ifdef MEM_OOR_ERR_EN
                    if (r_port_d) d_err <= r_oor;
                    else          i_err <= r_oor;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef MEM_OOR_ERR_EN
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_lat.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb_lat
// Brief    : Directed plus randomized bench for mem_arb_lat against a
//            transaction-level timing/data model.
// Revision : 1.0
// ============================================================================
module tb_mem_arb_lat;

    localparam int AB    = 10;
    localparam int WORDS = 1000;
    localparam int LAT   = 6;
`ifdef MEM_OOR_ERR_EN
    localparam bit OOR_ERR = 1'b1;
`else
    localparam bit OOR_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req, d_req, d_we;
    logic [AB-1:0] i_addr, d_addr;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata, i_rdata, d_rdata;
    logic          i_valid, i_err, d_valid, d_err, busy;

    logic          i1_req, d1_req, d1_we;
    logic [3:0]    i1_addr, d1_addr, d1_be;
    logic [31:0]   d1_wdata, i1_rdata, d1_rdata;
    logic          i1_valid, i1_err, d1_valid, d1_err, busy1;

    mem_arb_lat #(.WORDS(WORDS), .ADDR_BITS(AB), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .busy(busy)
    );

    mem_arb_lat #(.WORDS(16), .ADDR_BITS(4), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_valid(i1_valid), .i_err(i1_err),
        .d_req(d1_req), .d_we(d1_we), .d_be(d1_be), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_rdata(d1_rdata), .d_valid(d1_valid), .d_err(d1_err), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction model: acceptance edge, completion edge and data of the last grant.
    logic [31:0] mmem [WORDS];
    int          edge_n = 0, free_edge = 0, acc_edge = 0, done_edge = 0, upd_edge = 0;
    bit          active = 0, port_d = 0, last_i = 1, exp_err = 0, upd_pend = 0;
    logic [31:0] upd_val = 0, exp_ird = 0, exp_drd = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [AB-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AB'(WORDS + int'($urandom_range(0, 23)));
        return AB'($urandom_range(0, 15));
    endfunction

    task automatic step();
        logic [AB-1:0] a;
        bit oor, wr, fast, vld;
        @(posedge clk);
        edge_n++;
        if (!reset) begin
            active = 0; upd_pend = 0; last_i = 1; free_edge = 0;
            exp_ird = 32'h0; exp_drd = 32'h0;
        end else begin
            if (edge_n >= free_edge && (i_req || d_req)) begin
                port_d = d_req && (!i_req || last_i);
                last_i = !port_d;
                a      = port_d ? d_addr : i_addr;
                oor    = int'(a) >= WORDS;
                wr     = port_d && d_we;
                if (wr && !oor)
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) mmem[a][8*b +: 8] = d_wdata[8*b +: 8];
                fast      = wr || (OOR_ERR && oor);
                acc_edge  = edge_n;
                done_edge = fast ? edge_n + 1 : edge_n + LAT + 1;
                free_edge = done_edge + 1;
                active    = 1;
                exp_err   = OOR_ERR && oor;
                upd_pend  = !wr || (OOR_ERR && oor);
                upd_edge  = done_edge - 1;
                if (oor) upd_val = 32'h0;
                else     upd_val = mmem[a];
            end
            if (upd_pend && edge_n == upd_edge) begin
                if (port_d) exp_drd = upd_val;
                else        exp_ird = upd_val;
                upd_pend = 0;
            end
        end
        @(negedge clk);
        vld = active && (edge_n == done_edge);
        check_val("i_valid", 32'(i_valid), 32'(vld && !port_d));
        check_val("d_valid", 32'(d_valid), 32'(vld && port_d));
        check_val("i_err",   32'(i_err),   32'(vld && !port_d && exp_err));
        check_val("d_err",   32'(d_err),   32'(vld && port_d && exp_err));
        check_val("busy",    32'(busy),    32'(active && edge_n >= acc_edge && edge_n < done_edge));
        check_val("i_rdata", i_rdata, exp_ird);
        check_val("d_rdata", d_rdata, exp_drd);
    endtask

    task automatic access(input bit pd, input bit we, input logic [3:0] be, input logic [AB-1:0] a,
                          input logic [31:0] wd, output int lat, output int nbusy, output bit e);
        int t0;
        bit seen;
        t0 = edge_n; seen = 0; lat = -1; nbusy = 0; e = 0;
        if (pd) begin d_req = 1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; end
        else    begin i_req = 1; i_addr = a; end
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            if (busy) nbusy++;
            if (pd ? d_valid : i_valid) begin
                seen = 1; lat = edge_n - t0; e = pd ? d_err : i_err;
            end
        end
        d_req = 0; i_req = 0;
        check_val("access_done", 32'(seen), 32'd1);
    endtask

    initial begin
        int lat, nb, nv, last;
        bit e;
        int order[4];

        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        i1_req = 0; i1_addr = '0; d1_req = 0; d1_we = 0; d1_be = '0; d1_addr = '0; d1_wdata = '0;
        for (int k = 0; k < WORDS; k++) mmem[k] = 32'h0;

        repeat (3) step();
        reset = 1;

        access(1, 1, 4'hF, 10'd3, 32'h11223344, lat, nb, e);
        check_val("wr_lat", 32'(lat), 32'd2);
        check_val("wr_busy", 32'(nb), 32'd1);
        access(1, 1, 4'b0101, 10'd3, 32'hDEADBEEF, lat, nb, e);
        access(1, 0, 4'h0, 10'd3, 32'h0, lat, nb, e);
        check_val("rd_lat", 32'(lat), 32'(LAT + 2));
        check_val("rd_mask", d_rdata, 32'h11AD33EF);
        access(0, 0, 4'h0, 10'd3, 32'h0, lat, nb, e);
        check_val("if_lat", 32'(lat), 32'(LAT + 2));
        check_val("if_busy", 32'(nb), 32'(LAT + 1));
        check_val("if_data", i_rdata, 32'h11AD33EF);

        access(1, 1, 4'hF, 10'd4, 32'h0BADF00D, lat, nb, e);
        access(0, 0, 4'h0, 10'd4, 32'h0, lat, nb, e);
        check_val("if_data4", i_rdata, 32'h0BADF00D);

        // Both ports held high: last grant was fetch, so data wins first.
        i_req = 1; i_addr = 10'd4; d_req = 1; d_we = 0; d_addr = 10'd3;
        nv = 0;
        for (int k = 0; k < 100 && nv < 4; k++) begin
            step();
            if (d_valid && nv < 4) begin order[nv] = 1; nv++; end
            if (i_valid && nv < 4) begin order[nv] = 0; nv++; end
        end
        i_req = 0; d_req = 0;
        check_val("tie_count", 32'(nv), 32'd4);
        for (int k = 0; k < 4; k++) check_val("tie_order", 32'(order[k]), 32'((k % 2) == 0));

        // Reset in the middle of a read.
        d_req = 1; d_we = 0; d_addr = 10'd3;
        step();
        d_req = 0;
        step(); step();
        reset = 0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_d_rdata", d_rdata, 32'h0);
        check_val("rst_i_rdata", i_rdata, 32'h0);
        check_val("rst_valid", 32'({i_valid, d_valid}), 32'd0);
        repeat (3) step();
        reset = 1;
        repeat (10) step();
        access(1, 0, 4'h0, 10'd3, 32'h0, lat, nb, e);
        check_val("rst_keep", d_rdata, 32'h11AD33EF);

        // Zero byte enables complete but write nothing.
        access(1, 1, 4'h0, 10'd3, 32'hFFFFFFFF, lat, nb, e);
        check_val("be0_lat", 32'(lat), 32'd2);
        access(1, 0, 4'h0, 10'd3, 32'h0, lat, nb, e);
        check_val("be0_data", d_rdata, 32'h11AD33EF);

        // First address past the end of the array.
        access(1, 0, 4'h0, 10'(WORDS), 32'h0, lat, nb, e);
        check_val("oor_lat", 32'(lat), OOR_ERR ? 32'd2 : 32'(LAT + 2));
        check_val("oor_err", 32'(e), 32'(OOR_ERR));
        check_val("oor_data", d_rdata, 32'h0);

        for (int c = 0; c < 2000; c++) begin
            step();
            if (!i_req || i_valid) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = rand_addr();
            end
            if (!d_req || d_valid) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom);
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
        end
        i_req = 0; d_req = 0;
        repeat (LAT + 3) step();

        // LATENCY=1 instance: two writes, then back-to-back fetches with req held.
        for (int w = 0; w < 2; w++) begin
            int t;
            bit s;
            t = 0; s = 0;
            @(negedge clk);
            d1_req = 1; d1_we = 1; d1_be = 4'hF;
            d1_addr  = (w == 1) ? 4'd5 : 4'd2;
            d1_wdata = (w == 1) ? 32'hC0DE0005 : 32'hC0DE0002;
            for (int k = 1; k <= 10 && !s; k++) begin
                @(negedge clk);
                if (d1_valid) begin s = 1; t = k; end
            end
            d1_req = 0;
            check_val("l1_wr_lat", 32'(t), 32'd2);
        end
        i1_req = 1; i1_addr = 4'd2; nv = 0; last = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (i1_valid) begin
                if (nv > 0) check_val("l1_period", 32'(k - last), 32'd3);
                check_val("l1_data", i1_rdata, (i1_addr == 4'd2) ? 32'hC0DE0002 : 32'hC0DE0005);
                last = k; nv++;
                i1_addr = (i1_addr == 4'd2) ? 4'd5 : 4'd2;
            end
        end
        i1_req = 0;
        check_val("l1_count", 32'(nv), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
